// File: rtl/data_memory_responder_if.sv
`timescale 1ns/1ps
// Request/response bundle between the core datapath (master) and the data-memory responder (slave).
interface data_memory_responder_if;
    logic        MemRead;
    logic        MemWrite;
    logic [2:0]  Funct3;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic        Ready;
    logic        RespValid;
    logic [31:0] ReadData;
    logic        Error;

    modport master (
        output MemRead, MemWrite, Funct3, Address, WriteData,
        input  Ready, RespValid, ReadData, Error
    );

    modport slave (
        input  MemRead, MemWrite, Funct3, Address, WriteData,
        output Ready, RespValid, ReadData, Error
    );
endinterface

// File: rtl/data_memory_responder.sv
`timescale 1ns/1ps
// Data-memory responder: accepts one load/store per handshake, models a RAM with a fixed
// access latency and performs RV32I byte/half/word lane selection and load extension.
module data_memory_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic                   clock,
    input  logic                   Reset,
    data_memory_responder_if.slave bus
);

    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ready_q, ready_d;
    logic              resp_valid_q, resp_valid_d;
    logic              error_q, error_d;
    logic [31:0]       read_data_q, read_data_d;
    logic              is_store_q, is_store_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;

    logic [31:0]       mem [DEPTH_WORDS];

    logic [IDX_W-1:0]  word_idx;
    logic [31:0]       cur_word;
    logic [31:0]       lane_data;
    logic [31:0]       load_value;
    logic [31:0]       store_lanes;
    logic [31:0]       merged_word;
    logic [3:0]        byte_en;
    logic              funct3_ok;
    logic              misaligned;
    logic              out_of_range;
    logic              access_err;
    logic              access_done;
    logic              commit;

    assign word_idx     = addr_q[IDX_W+1:2];
    assign cur_word     = mem[word_idx];
    assign lane_data    = cur_word >> {addr_q[1:0], 3'b000};
    assign store_lanes  = wdata_q << {addr_q[1:0], 3'b000};
    assign out_of_range = ({2'b00, addr_q[31:2]} >= 32'(DEPTH_WORDS));
    assign misaligned   = ((funct3_q[1:0] == 2'b01) && addr_q[0]) ||
                          ((funct3_q[1:0] == 2'b10) && (addr_q[1:0] != 2'b00));
    assign access_err   = !funct3_ok || misaligned || out_of_range;
    assign access_done  = (state_q == ST_WAIT) && (cnt_q == '0);
    assign commit       = access_done && is_store_q && !access_err;

    // Unsigned sizes exist only for loads, so they are rejected for stores.
    always_comb begin
        funct3_ok = 1'b0;
        case (funct3_q)
            3'b000, 3'b001, 3'b010: funct3_ok = 1'b1;
            3'b100, 3'b101:         funct3_ok = !is_store_q;
            default:                funct3_ok = 1'b0;
        endcase
    end

    always_comb begin
        load_value = '0;
        case (funct3_q)
            3'b000:  load_value = {{24{lane_data[7]}}, lane_data[7:0]};
            3'b001:  load_value = {{16{lane_data[15]}}, lane_data[15:0]};
            3'b010:  load_value = cur_word;
            3'b100:  load_value = {24'h000000, lane_data[7:0]};
            3'b101:  load_value = {16'h0000, lane_data[15:0]};
            default: load_value = '0;
        endcase
    end

    always_comb begin
        byte_en = 4'b0000;
        case (funct3_q)
            3'b000:  byte_en = 4'b0001 << addr_q[1:0];
            3'b001:  byte_en = addr_q[1] ? 4'b1100 : 4'b0011;
            3'b010:  byte_en = 4'b1111;
            default: byte_en = 4'b0000;
        endcase
    end

    always_comb begin
        merged_word = cur_word;
        for (int i = 0; i < 4; i++) begin
            if (byte_en[i]) begin
                merged_word[8*i +: 8] = store_lanes[8*i +: 8];
            end
        end
    end

    // Request is captured only when Ready was already high, so strobes during an access are dropped.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        ready_d      = ready_q;
        resp_valid_d = 1'b0;
        error_d      = 1'b0;
        read_data_d  = read_data_q;
        is_store_d   = is_store_q;
        funct3_d     = funct3_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        case (state_q)
            ST_IDLE: begin
                ready_d = 1'b1;
                if (ready_q && (bus.MemRead || bus.MemWrite)) begin
                    is_store_d = bus.MemWrite;
                    funct3_d   = bus.Funct3;
                    addr_d     = bus.Address;
                    wdata_d    = bus.WriteData;
                    cnt_d      = CNT_LOAD;
                    ready_d    = 1'b0;
                    state_d    = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (access_done) begin
                    state_d      = ST_RESP;
                    resp_valid_d = 1'b1;
                    error_d      = access_err;
                    read_data_d  = (access_err || is_store_q) ? 32'h0 : load_value;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
                ready_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge Reset) begin
        if (Reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            ready_q      <= 1'b0;
            resp_valid_q <= 1'b0;
            error_q      <= 1'b0;
            read_data_q  <= '0;
            is_store_q   <= 1'b0;
            funct3_q     <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ready_q      <= ready_d;
            resp_valid_q <= resp_valid_d;
            error_q      <= error_d;
            read_data_q  <= read_data_d;
            is_store_q   <= is_store_d;
            funct3_q     <= funct3_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
        end
    end

    // The array has no reset; an access aborted by Reset never reaches the commit cycle.
    always_ff @(posedge clock) begin
        if (commit) begin
            mem[word_idx] <= merged_word;
        end
    end

    assign bus.Ready     = ready_q;
    assign bus.RespValid = resp_valid_q;
    assign bus.ReadData  = read_data_q;
    assign bus.Error     = error_q;

endmodule

// File: tb/tb_data_memory_responder.sv
`timescale 1ns/1ps
// Self-checking bench for data_memory_responder: directed literal checks plus a randomized
// run scored every cycle against a timestamp-based behavioural model of the responder.
module tb_data_memory_responder;

    localparam int DEPTH   = 256;
    localparam int LAT     = 2;
    localparam int TIMEOUT = 50;

    logic clock = 1'b0;
    logic Reset = 1'b1;

    data_memory_responder_if bus();

    data_memory_responder #(
        .DEPTH_WORDS(DEPTH),
        .LATENCY    (LAT)
    ) dut (
        .clock(clock),
        .Reset(Reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: each accepted request is stamped with the edge on which its
    // response must appear; the memory is a plain word array updated byte by byte.
    logic [31:0] model_mem [DEPTH];
    bit          m_ready   = 1'b0;
    bit          m_busy    = 1'b0;
    bit          m_resp    = 1'b0;
    bit          m_err     = 1'b0;
    logic [31:0] m_rdata   = '0;
    int unsigned edge_n    = 0;
    int unsigned resp_edge = 0;
    bit          r_wr;
    logic [2:0]  r_f3;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;

    initial begin
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    end

    always @(posedge clock or posedge Reset) begin
        bit          was_ready;
        bit          legal;
        int          size;
        int          off;
        logic [31:0] w;
        logic [31:0] v;
        if (Reset) begin
            m_ready = 1'b0;
            m_busy  = 1'b0;
            m_resp  = 1'b0;
            m_err   = 1'b0;
            m_rdata = '0;
        end else begin
            was_ready = m_ready;
            edge_n++;
            m_resp = 1'b0;
            m_err  = 1'b0;
            if (m_busy && edge_n == resp_edge) begin
                size   = 1 << r_f3[1:0];
                off    = int'(r_addr % 4);
                legal  = r_wr ? (r_f3 <= 3'd2) : (r_f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
                m_resp = 1'b1;
                if (!legal || (r_addr % size) != 0 || (r_addr / 4) >= DEPTH) begin
                    m_err   = 1'b1;
                    m_rdata = '0;
                end else begin
                    w = model_mem[r_addr / 4];
                    if (r_wr) begin
                        for (int b = 0; b < size; b++) w[8*(off+b) +: 8] = r_wdata[8*b +: 8];
                        model_mem[r_addr / 4] = w;
                        m_rdata = '0;
                    end else begin
                        v = w >> (8 * off);
                        if (size == 1)      m_rdata = r_f3[2] ? 32'(v[7:0])  : 32'($signed(v[7:0]));
                        else if (size == 2) m_rdata = r_f3[2] ? 32'(v[15:0]) : 32'($signed(v[15:0]));
                        else                m_rdata = w;
                    end
                end
            end else if (m_busy && edge_n == resp_edge + 1) begin
                m_busy = 1'b0;
            end
            if (was_ready && (bus.MemRead || bus.MemWrite)) begin
                r_wr      = bus.MemWrite;
                r_f3      = bus.Funct3;
                r_addr    = bus.Address;
                r_wdata   = bus.WriteData;
                m_busy    = 1'b1;
                resp_edge = edge_n + LAT;
            end
            m_ready = !m_busy;
        end
    end

    // Every cycle: all four outputs must agree with the model.
    always @(negedge clock) begin
        check_output("ready",      32'(bus.Ready),     32'(m_ready));
        check_output("resp_valid", 32'(bus.RespValid), 32'(m_resp));
        check_output("error",      32'(bus.Error),     32'(m_err));
        check_output("read_data",  bus.ReadData,       m_rdata);
    end

    task automatic wait_ready();
        int guard = 0;
        @(negedge clock);
        while (!bus.Ready && guard < TIMEOUT) begin
            @(negedge clock);
            guard++;
        end
        check_output("ready_timeout", 32'(bus.Ready), 32'd1);
    endtask

    task automatic apply_stimulus(input bit rd_en, input bit wr_en, input logic [2:0] f3,
                                  input logic [31:0] addr, input logic [31:0] wdata,
                                  output logic [31:0] rdata, output bit err, output int lat);
        wait_ready();
        bus.MemRead   = rd_en;
        bus.MemWrite  = wr_en;
        bus.Funct3    = f3;
        bus.Address   = addr;
        bus.WriteData = wdata;
        @(posedge clock);
        #1;
        bus.MemRead  = 1'b0;
        bus.MemWrite = 1'b0;
        lat = 0;
        while (!bus.RespValid && lat < TIMEOUT) begin
            @(posedge clock);
            #1;
            lat++;
        end
        check_output("resp_timeout", 32'(bus.RespValid), 32'd1);
        rdata = bus.ReadData;
        err   = bus.Error;
    endtask

    logic [31:0] sweep_data [DEPTH];

    initial begin
        logic [31:0] rd;
        bit          er;
        int          lat;
        int          cnt_resp;
        int          cnt_ready;
        int          kind;
        logic [2:0]  f3;
        logic [31:0] addr;

        bus.MemRead   = 1'b0;
        bus.MemWrite  = 1'b0;
        bus.Funct3    = '0;
        bus.Address   = '0;
        bus.WriteData = '0;

        @(negedge clock);
        check_output("reset_ready",     32'(bus.Ready),     32'd0);
        check_output("reset_respvalid", 32'(bus.RespValid), 32'd0);
        check_output("reset_readdata",  bus.ReadData,       32'd0);
        check_output("reset_error",     32'(bus.Error),     32'd0);
        @(posedge clock);
        #1 Reset = 1'b0;

        $display("[TB] filling the array with random words");
        for (int i = 0; i < DEPTH; i++) begin
            sweep_data[i] = $urandom();
            apply_stimulus(1'b0, 1'b1, 3'b010, 32'(i * 4), sweep_data[i], rd, er, lat);
        end

        $display("[TB] word store and load");
        apply_stimulus(1'b0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, rd, er, lat);
        check_output("t1_sw_err",   32'(er),  32'd0);
        check_output("t1_sw_lat",   32'(lat), 32'd2);
        check_output("t1_sw_rdata", rd,       32'd0);
        apply_stimulus(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, rd, er, lat);
        check_output("t1_lw_rdata", rd,       32'hDEADBEEF);
        check_output("t1_lw_err",   32'(er),  32'd0);
        check_output("t1_lw_lat",   32'(lat), 32'd2);

        $display("[TB] byte lanes");
        apply_stimulus(1'b0, 1'b1, 3'b000, 32'h13, 32'h00000080, rd, er, lat);
        check_output("t2_sb_err", 32'(er), 32'd0);
        apply_stimulus(1'b1, 1'b0, 3'b000, 32'h13, 32'h0, rd, er, lat);
        check_output("t2_lb", rd, 32'hFFFFFF80);
        apply_stimulus(1'b1, 1'b0, 3'b100, 32'h13, 32'h0, rd, er, lat);
        check_output("t2_lbu", rd, 32'h00000080);
        apply_stimulus(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, rd, er, lat);
        check_output("t2_lw", rd, 32'h80ADBEEF);

        $display("[TB] half lanes and misalignment");
        apply_stimulus(1'b0, 1'b1, 3'b001, 32'h12, 32'h00001234, rd, er, lat);
        check_output("t3_sh_err", 32'(er), 32'd0);
        apply_stimulus(1'b1, 1'b0, 3'b001, 32'h11, 32'h0, rd, er, lat);
        check_output("t3_lh_mis_err",   32'(er), 32'd1);
        check_output("t3_lh_mis_rdata", rd,      32'd0);
        apply_stimulus(1'b1, 1'b0, 3'b101, 32'h12, 32'h0, rd, er, lat);
        check_output("t3_lhu", rd, 32'h00001234);

        $display("[TB] range and funct3 errors");
        apply_stimulus(1'b1, 1'b0, 3'b010, 32'h400, 32'h0, rd, er, lat);
        check_output("t4_lw_oor_err",   32'(er), 32'd1);
        check_output("t4_lw_oor_rdata", rd,      32'd0);
        apply_stimulus(1'b0, 1'b1, 3'b010, 32'h400, 32'h5A5A5A5A, rd, er, lat);
        check_output("t4_sw_oor_err", 32'(er), 32'd1);
        apply_stimulus(1'b1, 1'b0, 3'b010, 32'h0, 32'h0, rd, er, lat);
        check_output("t4_word0_kept", rd, sweep_data[0]);
        apply_stimulus(1'b1, 1'b0, 3'b010, 32'h3FC, 32'h0, rd, er, lat);
        check_output("t4_last_word",     rd,      sweep_data[DEPTH-1]);
        check_output("t4_last_word_err", 32'(er), 32'd0);
        apply_stimulus(1'b1, 1'b0, 3'b011, 32'h10, 32'h0, rd, er, lat);
        check_output("t4_f3_011_err", 32'(er), 32'd1);
        apply_stimulus(1'b0, 1'b1, 3'b100, 32'h10, 32'hFFFFFFFF, rd, er, lat);
        check_output("t4_sbu_err", 32'(er), 32'd1);
        apply_stimulus(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, rd, er, lat);
        check_output("t4_word10_kept", rd, 32'h1234BEEF);

        $display("[TB] continuous MemRead");
        wait_ready();
        bus.MemRead = 1'b1;
        bus.Funct3  = 3'b010;
        bus.Address = 32'h10;
        cnt_resp  = 0;
        cnt_ready = 0;
        for (int j = 0; j < 16; j++) begin
            @(posedge clock);
            #1;
            if (bus.RespValid) cnt_resp++;
            if (bus.Ready)     cnt_ready++;
        end
        bus.MemRead = 1'b0;
        check_output("t5_resp_count",  32'(cnt_resp),  32'd4);
        check_output("t5_ready_count", 32'(cnt_ready), 32'd4);

        $display("[TB] reset during a pending store");
        apply_stimulus(1'b0, 1'b1, 3'b010, 32'h20, 32'h000000AA, rd, er, lat);
        wait_ready();
        bus.MemWrite  = 1'b1;
        bus.Funct3    = 3'b010;
        bus.Address   = 32'h20;
        bus.WriteData = 32'h00000055;
        @(posedge clock);
        #1;
        bus.MemWrite = 1'b0;
        #1 Reset = 1'b1;
        @(negedge clock);
        check_output("t6_ready_in_reset", 32'(bus.Ready),     32'd0);
        check_output("t6_resp_in_reset",  32'(bus.RespValid), 32'd0);
        @(posedge clock);
        #1 Reset = 1'b0;
        @(negedge clock);
        check_output("t6_ready_before_edge", 32'(bus.Ready), 32'd0);
        cnt_resp = 0;
        for (int j = 0; j < 6; j++) begin
            @(posedge clock);
            #1;
            if (j == 0) check_output("t6_ready_first_edge", 32'(bus.Ready), 32'd1);
            if (bus.RespValid) cnt_resp++;
        end
        check_output("t6_no_resp", 32'(cnt_resp), 32'd0);
        apply_stimulus(1'b1, 1'b0, 3'b010, 32'h20, 32'h0, rd, er, lat);
        check_output("t6_old_value", rd, 32'h000000AA);

        $display("[TB] randomized traffic");
        for (int c = 0; c < 1500; c++) begin
            @(negedge clock);
            kind         = $urandom_range(0, 9);
            bus.MemRead  = (kind inside {[4:6], 9});
            bus.MemWrite = (kind inside {[7:9]});
            if ($urandom_range(0, 4) != 0) begin
                case ($urandom_range(0, 4))
                    0:       f3 = 3'b000;
                    1:       f3 = 3'b001;
                    2:       f3 = 3'b010;
                    3:       f3 = 3'b100;
                    default: f3 = 3'b101;
                endcase
            end else begin
                f3 = 3'($urandom_range(0, 7));
            end
            if ($urandom_range(0, 6) != 0) begin
                addr = 32'($urandom_range(0, DEPTH - 1)) << 2;
                if ($urandom_range(0, 4) == 0)  addr[1:0] = 2'($urandom_range(0, 3));
                else if (f3[1:0] == 2'b00)      addr[1:0] = 2'($urandom_range(0, 3));
                else if (f3[1:0] == 2'b01)      addr[1]   = 1'($urandom_range(0, 1));
            end else begin
                addr = $urandom() | 32'h00000400;
            end
            bus.Funct3    = f3;
            bus.Address   = addr;
            bus.WriteData = $urandom();
        end
        @(negedge clock);
        bus.MemRead  = 1'b0;
        bus.MemWrite = 1'b0;
        repeat (LAT + 6) @(negedge clock);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got no completion, expected finish before 1000000 ns");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
